sram_1024x11_ctrl: RTL and testbench

SRAM_1024X11_CTRL -- requirements
Module: sram_1024x11_ctrl

---
 rtl/sram_1024x11_ctrl_pkg.sv | 12 +
 rtl/sram_rsp_hold.sv | 56 +++++
 rtl/sram_1024x11_ctrl.sv | 94 +++++++++
 tb/tb_sram_1024x11_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sram_1024x11_ctrl_pkg.sv
// Shared sizing constants and FSM state type for the 1024x11 SRAM controller.
package sram_1024x11_ctrl_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 11;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    INIT     = 2'd1,
    RUN      = 2'd2
  } state_t;
endpackage

// File: rtl/sram_rsp_hold.sv
// Read response path: SRAM-sourced data, write-first bypass register and a
// hold register that freezes a response while the consumer back-pressures.
module sram_rsp_hold #(
  parameter int ADDR_W = sram_1024x11_ctrl_pkg::ADDR_W,
  parameter int DATA_W = sram_1024x11_ctrl_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_fire,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] sram_r_data,
  input  logic              resp_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data
);
  logic              infl;      // SRAM read data is on sram_r_data this cycle
  logic              byp_vld;   // response comes from the bypass register
  logic [DATA_W-1:0] byp_data;
  logic              hold_vld;  // response comes from the hold register
  logic [DATA_W-1:0] hold_data;
  logic              collide;

  // Same-address write in the read's cycle wins over the macro's collision result.
  assign collide    = wr_fire && (wr_addr == rd_addr);
  assign resp_valid = infl || byp_vld || hold_vld;
  assign resp_data  = hold_vld ? hold_data : (byp_vld ? byp_data : sram_r_data);

  // A new read only fires once the previous response is gone or being taken,
  // so fire always replaces whatever was presented before.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      infl      <= 1'b0;
      byp_vld   <= 1'b0;
      byp_data  <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (rd_fire) begin
      infl     <= !collide;
      byp_vld  <= collide;
      hold_vld <= 1'b0;
      if (collide) byp_data <= wr_data;
    end else if (resp_valid && resp_ready) begin
      infl     <= 1'b0;
      byp_vld  <= 1'b0;
      hold_vld <= 1'b0;
    end else if (infl) begin
      // Stalled SRAM response: snapshot it so later writes cannot change it.
      infl      <= 1'b0;
      hold_vld  <= 1'b1;
      hold_data <= sram_r_data;
    end
  end
endmodule

// File: rtl/sram_1024x11_ctrl.sv
// SRAM controller: init sweep after reset, then one read and one write per
// cycle with ready/valid handshakes and a registered response path.
module sram_1024x11_ctrl #(
  parameter int              ADDR_W     = sram_1024x11_ctrl_pkg::ADDR_W,
  parameter int              DATA_W     = sram_1024x11_ctrl_pkg::DATA_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              init_done,
  output logic              sram_r_en,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [DATA_W-1:0] sram_w_data
);
  import sram_1024x11_ctrl_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              run_q;
  logic              rd_fire;
  logic              wr_fire;
  logic              in_init;

  // Sequencer: wait one edge after reset, sweep every address, then serve traffic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RST_WAIT;
      cnt   <= '0;
      run_q <= 1'b0;
    end else begin
      case (state)
        RST_WAIT: begin
          state <= INIT;
          cnt   <= '0;
        end
        INIT: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= RUN;
            run_q <= 1'b1;
          end
        end
        RUN:     run_q <= 1'b1;
        default: begin
          state <= RST_WAIT;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_init   = (state == INIT);
  assign init_done = run_q;
  assign wr_ready  = run_q;
  assign req_ready = run_q && (!resp_valid || resp_ready);
  assign rd_fire   = req_valid && req_ready;
  assign wr_fire   = wr_valid && wr_ready;

  assign sram_r_en   = rd_fire;
  assign sram_r_addr = req_addr;
  assign sram_w_en   = in_init || wr_fire;
  assign sram_w_addr = in_init ? cnt : wr_addr;
  assign sram_w_data = in_init ? INIT_VALUE : wr_data;

  sram_rsp_hold #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rsp (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_fire     (rd_fire),
    .rd_addr     (req_addr),
    .wr_fire     (wr_fire),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sram_r_data (sram_r_data),
    .resp_ready  (resp_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data)
  );
endmodule

// File: tb/tb_sram_1024x11_ctrl.sv
// Bench for sram_1024x11_ctrl: behavioural SRAM plus a memory/response-queue
// reference model, directed scenarios and randomized traffic.
module tb_sram_1024x11_ctrl;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [9:0]  req_addr;
  logic        resp_valid, resp_ready;
  logic [10:0] resp_data;
  logic        wr_valid, wr_ready;
  logic [9:0]  wr_addr;
  logic [10:0] wr_data;
  logic        init_done;
  logic        sram_r_en, sram_w_en;
  logic [9:0]  sram_r_addr, sram_w_addr;
  logic [10:0] sram_r_data, sram_w_data;

  int n_vec = 0;
  int n_err = 0;

  logic [10:0] sram_mem [0:1023];
  logic [10:0] ref_mem  [0:1023];
  logic [10:0] q[$];

  always #5 clock = ~clock;

  sram_1024x11_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done),
    .sram_r_en(sram_r_en), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
    .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data)
  );

  // Behavioural 1R1W macro: registered read, read-old on same-edge collision.
  always @(posedge clock) begin
    if (sram_r_en) sram_r_data <= sram_mem[sram_r_addr];
    if (sram_w_en) sram_mem[sram_w_addr] <= sram_w_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One RUN-mode cycle: drive, check against the model, advance the model.
  task automatic cyc(input bit rv, input logic [9:0] ra, input bit wv,
                     input logic [9:0] wa, input logic [10:0] wd, input bit rr);
    bit exp_rdy, fire;
    req_valid = rv; req_addr = ra;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    resp_ready = rr;
    #1;
    exp_rdy = (q.size() == 0) || rr;
    fire    = rv && exp_rdy;
    chk("req_ready", req_ready, exp_rdy);
    chk("wr_ready", wr_ready, 1);
    chk("resp_valid", resp_valid, q.size() != 0);
    if (q.size() != 0) chk("resp_data", resp_data, q[0]);
    chk("sram_r_en", sram_r_en, fire);
    if (fire) chk("sram_r_addr", sram_r_addr, ra);
    chk("sram_w_en", sram_w_en, wv);
    @(posedge clock);
    if (q.size() != 0 && rr) void'(q.pop_front());
    if (fire) q.push_back((wv && wa == ra) ? wd : ref_mem[ra]);
    if (wv) ref_mem[wa] = wd;
    @(negedge clock);
  endtask

  // Follow the init sweep after reset release; a read request is kept pending throughout.
  task automatic sweep();
    int k;
    req_valid = 1'b1; req_addr = 10'd7;
    wr_valid = 1'b0; resp_ready = 1'b1;
    k = 0;
    while (!sram_w_en && k < 8) begin
      @(negedge clock);
      k++;
    end
    chk("init_start", sram_w_en, 1);
    if (!sram_w_en) return;
    for (int i = 0; i < 1024; i++) begin
      chk("init_w_en", sram_w_en, 1);
      chk("init_w_addr", sram_w_addr, i);
      chk("init_w_data", sram_w_data, 0);
      chk("init_busy", {init_done, req_ready, wr_ready, sram_r_en}, 0);
      @(negedge clock);
    end
    chk("init_done", init_done, 1);
    chk("post_init_w_en", sram_w_en, 0);
    for (int a = 0; a < 1024; a++) ref_mem[a] = 11'd0;
    q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b1; req_addr = '0;
    wr_valid = 1'b1; wr_addr = '0; wr_data = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ready", {req_ready, wr_ready}, 0);
    chk("rst_sram_en", {sram_r_en, sram_w_en}, 0);
    reset_n = 1'b1;
    sweep();

    // Stalled request from init is served first and reads the init value.
    cyc(1, 10'd7, 0, 0, 0, 1);
    // Write then read of address 5.
    cyc(0, 0, 1, 10'd5, 11'h7FF, 1);
    cyc(1, 10'd5, 0, 0, 0, 1);
    chk("r5_data", resp_data, 11'h7FF);
    cyc(0, 0, 0, 0, 0, 1);

    // Back-to-back reads with a 3-cycle consumer stall.
    cyc(0, 0, 1, 10'd1, 11'h101, 1);
    cyc(0, 0, 1, 10'd2, 11'h202, 1);
    cyc(0, 0, 1, 10'd3, 11'h303, 1);
    cyc(1, 10'd1, 0, 0, 0, 1);
    cyc(1, 10'd2, 0, 0, 0, 0);
    cyc(1, 10'd2, 0, 0, 0, 0);
    cyc(1, 10'd2, 0, 0, 0, 0);
    chk("stall_hold", resp_data, 11'h101);
    cyc(1, 10'd2, 0, 0, 0, 1);
    cyc(1, 10'd3, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Same-cycle read/write bypass, then a write under a held response.
    cyc(0, 0, 1, 10'd9, 11'h2AA, 1);
    cyc(1, 10'd9, 1, 10'd9, 11'h155, 0);
    cyc(0, 0, 1, 10'd9, 11'h0AA, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("byp_held", resp_data, 11'h155);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 10'd9, 0, 0, 0, 1);
    chk("r9_after", resp_data, 11'h0AA);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset with a held SRAM response.
    cyc(1, 10'd4, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pre_rst_valid", resp_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_flags", {init_done, req_ready, wr_ready, sram_w_en}, 0);
    q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    sweep();

    // Randomized traffic over a small address window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(1), 10'($urandom_range(15)), $urandom_range(2) == 0,
          10'($urandom_range(15)), 11'($urandom), $urandom_range(3) != 0);
    end
    cyc(0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
